// File: rtl/mv_best_select.sv
// Integer-pel motion-vector decision: adds lambda-weighted MV cost to each
// candidate SAD of a raster-ordered full search and keeps the cheapest.
module mv_best_select #(
    parameter int SAD_WIDTH  = 16,
    parameter int SR         = 8,
    parameter int MV_WIDTH   = 5,
    parameter int LAMBDA     = 4,
    parameter int COST_WIDTH = SAD_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         sad_valid,
    output logic                         sad_ready,
    input  logic [SAD_WIDTH-1:0]         sad_in,
    output logic                         best_valid,
    input  logic                         best_ready,
    output logic signed [MV_WIDTH-1:0]   best_mvx,
    output logic signed [MV_WIDTH-1:0]   best_mvy,
    output logic [COST_WIDTH-1:0]        best_cost,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic signed [MV_WIDTH-1:0] MV_MAX = MV_WIDTH'(SR);
    localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-SR);

    state_t state, state_nx;

    logic signed [MV_WIDTH-1:0] cur_mvx, cur_mvy;
    logic [MV_WIDTH-1:0]        abs_x, abs_y;
    logic [COST_WIDTH-1:0]      mv_cost, cost;
    logic                       accept, last;

    function automatic logic [MV_WIDTH-1:0] abs_mv(
        input logic signed [MV_WIDTH-1:0] v
    );
        logic [MV_WIDTH-1:0] neg;
        neg = -v;
        return v[MV_WIDTH-1] ? neg : v;
    endfunction

    always_comb begin
        abs_x   = abs_mv(cur_mvx);
        abs_y   = abs_mv(cur_mvy);
        mv_cost = COST_WIDTH'(LAMBDA)
                * (COST_WIDTH'(abs_x) + COST_WIDTH'(abs_y));
        cost    = COST_WIDTH'(sad_in) + mv_cost;
    end

    assign accept = sad_valid && sad_ready;
    assign last   = accept && (cur_mvx == MV_MAX) && (cur_mvy == MV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sad_ready  = 1'b0;
        best_valid = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = SEARCH;
            end
            SEARCH: begin
                sad_ready = 1'b1;
                busy      = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                best_valid = 1'b1;
                busy       = 1'b1;
                if (best_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strict compare: on ties the earlier raster candidate is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mvx   <= '0;
            cur_mvy   <= '0;
            best_mvx  <= '0;
            best_mvy  <= '0;
            best_cost <= '0;
        end else if (state == IDLE && start) begin
            cur_mvx   <= MV_MIN;
            cur_mvy   <= MV_MIN;
            best_mvx  <= '0;
            best_mvy  <= '0;
            best_cost <= '1;
        end else if (accept) begin
            if (cost < best_cost) begin
                best_cost <= cost;
                best_mvx  <= cur_mvx;
                best_mvy  <= cur_mvy;
            end
            if (cur_mvx == MV_MAX) begin
                cur_mvx <= MV_MIN;
                cur_mvy <= cur_mvy + MV_WIDTH'(1);
            end else begin
                cur_mvx <= cur_mvx + MV_WIDTH'(1);
            end
        end
    end

endmodule
